alu_hilo: RTL

ALU_HILO -- requirements
Module: alu_hilo

---
 rtl/alu_hilo_if.sv | 26 ++
 rtl/alu_hilo.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/alu_hilo_if.sv
// Request/response bundle of the HI/LO multiply-divide unit.
// Signal prefixes are from the unit's point of view.
interface alu_hilo_if #(
  parameter int WIDTH = 32
) ();
  logic             i_start;
  logic [3:0]       i_op;
  logic [WIDTH-1:0] i_a;
  logic [WIDTH-1:0] i_b;
  logic             o_busy;
  logic             o_done;
  logic [WIDTH-1:0] o_result;
  logic [WIDTH-1:0] o_hi;
  logic [WIDTH-1:0] o_lo;
  logic             o_div_by_zero;

  modport master (
    output i_start, i_op, i_a, i_b,
    input  o_busy, o_done, o_result, o_hi, o_lo, o_div_by_zero
  );

  modport slave (
    input  i_start, i_op, i_a, i_b,
    output o_busy, o_done, o_result, o_hi, o_lo, o_div_by_zero
  );
endinterface

// File: rtl/alu_hilo.sv
// HI/LO multiply, multiply-accumulate and restoring-divide unit with move ops.
// Operands are latched at Start; HI/LO are written only in ACC, FIX or by moves.
module alu_hilo #(
  parameter int WIDTH      = 32,
  parameter int MUL_STAGES = 1
) (
  input logic       i_clk,
  input logic       i_rst_n,
  alu_hilo_if.slave bus
);
  localparam int CW = $clog2(WIDTH + 1) + 1;
  localparam int PW = 2 * WIDTH;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0, S_MUL = 3'd1, S_ACC = 3'd2, S_DIV = 3'd3, S_FIX = 3'd4, S_FIN = 3'd5
  } state_t;

  state_t           r_state, w_state_nxt;
  logic [CW-1:0]    r_cnt;
  logic [2:0]       r_op;
  logic [WIDTH-1:0] r_a, r_b, r_hi, r_lo, r_result, r_rem, r_quo, r_dvs;
  logic [PW-1:0]    r_pipe [0:MUL_STAGES];
  logic             r_busy, r_done, r_dbz;
  logic             w_busy_nxt, w_done_nxt, w_dbz_nxt;
  logic             w_in_mul, w_in_div, w_signed, w_a_neg, w_b_neg;
  logic [PW-1:0]    w_ax, w_bx, w_prod, w_hilo, w_acc;
  logic [WIDTH:0]   w_shift, w_diff;
  logic [WIDTH-1:0] w_a_mag, w_b_mag, w_q_fix, w_r_fix;

  assign w_in_mul = (bus.i_op < 4'd6);
  assign w_in_div = (bus.i_op == 4'd6) || (bus.i_op == 4'd7);
  assign w_signed = ~r_op[0];
  assign w_a_neg  = w_signed & r_a[WIDTH-1];
  assign w_b_neg  = w_signed & r_b[WIDTH-1];

  // Sign-extending to 2*WIDTH makes one truncated multiply serve both signednesses.
  assign w_ax   = {{WIDTH{w_a_neg}}, r_a};
  assign w_bx   = {{WIDTH{w_b_neg}}, r_b};
  assign w_prod = w_ax * w_bx;
  assign w_hilo = {r_hi, r_lo};

  assign w_a_mag = w_a_neg ? ({WIDTH{1'b0}} - r_a) : r_a;
  assign w_b_mag = w_b_neg ? ({WIDTH{1'b0}} - r_b) : r_b;
  assign w_shift = {r_rem, r_quo[WIDTH-1]};
  assign w_diff  = w_shift - {1'b0, r_dvs};
  assign w_q_fix = (w_a_neg ^ w_b_neg) ? ({WIDTH{1'b0}} - r_quo) : r_quo;
  assign w_r_fix = w_a_neg ? ({WIDTH{1'b0}} - r_rem) : r_rem;

  // Accumulate selection for the MUL family
  always_comb begin
    case (r_op[2:1])
      2'b01:   w_acc = w_hilo + r_pipe[MUL_STAGES];
      2'b10:   w_acc = w_hilo - r_pipe[MUL_STAGES];
      default: w_acc = r_pipe[MUL_STAGES];
    endcase
  end

  // State register
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state logic; DIV spends its first cycle forming magnitudes and checking B
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: begin
        if (bus.i_start && w_in_mul)      w_state_nxt = S_MUL;
        else if (bus.i_start && w_in_div) w_state_nxt = S_DIV;
        else                              w_state_nxt = S_IDLE;
      end
      S_MUL: begin
        if (r_cnt == CW'(MUL_STAGES)) w_state_nxt = S_ACC;
        else                          w_state_nxt = S_MUL;
      end
      S_ACC: w_state_nxt = S_FIN;
      S_DIV: begin
        if (r_cnt == {CW{1'b0}} && r_b == {WIDTH{1'b0}}) w_state_nxt = S_FIN;
        else if (r_cnt == CW'(WIDTH))                    w_state_nxt = S_FIX;
        else                                             w_state_nxt = S_DIV;
      end
      S_FIX:   w_state_nxt = S_FIN;
      S_FIN:   w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Output logic: next values of the registered status outputs
  always_comb begin
    w_busy_nxt = 1'b0;
    w_done_nxt = 1'b0;
    w_dbz_nxt  = 1'b0;
    if (w_state_nxt == S_MUL || w_state_nxt == S_ACC || w_state_nxt == S_DIV || w_state_nxt == S_FIX) begin
      w_busy_nxt = 1'b1;
    end else begin
      w_busy_nxt = 1'b0;
    end
    if (w_state_nxt == S_FIN) begin
      w_done_nxt = 1'b1;
      w_dbz_nxt  = (r_state == S_DIV);
    end else begin
      w_done_nxt = (r_state == S_IDLE) && bus.i_start && (bus.i_op >= 4'd8);
      w_dbz_nxt  = 1'b0;
    end
  end

  // Status output registers and phase counter
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_busy <= 1'b0;
      r_done <= 1'b0;
      r_dbz  <= 1'b0;
      r_cnt  <= {CW{1'b0}};
    end else begin
      r_busy <= w_busy_nxt;
      r_done <= w_done_nxt;
      r_dbz  <= w_dbz_nxt;
      if (w_state_nxt != r_state)                  r_cnt <= {CW{1'b0}};
      else if (r_state == S_MUL || r_state == S_DIV) r_cnt <= r_cnt + CW'(1);
      else                                         r_cnt <= r_cnt;
    end
  end

  // Multiply pipeline; free-running, sampled by ACC after MUL_STAGES+1 cycles
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      for (int i = 0; i <= MUL_STAGES; i++) r_pipe[i] <= {PW{1'b0}};
    end else begin
      r_pipe[0] <= w_prod;
      for (int i = 1; i <= MUL_STAGES; i++) r_pipe[i] <= r_pipe[i-1];
    end
  end

  // Operand latch, HI/LO/Result and divider datapath
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_op     <= 3'd0;
      r_a      <= {WIDTH{1'b0}};
      r_b      <= {WIDTH{1'b0}};
      r_hi     <= {WIDTH{1'b0}};
      r_lo     <= {WIDTH{1'b0}};
      r_result <= {WIDTH{1'b0}};
      r_rem    <= {WIDTH{1'b0}};
      r_quo    <= {WIDTH{1'b0}};
      r_dvs    <= {WIDTH{1'b0}};
    end else begin
      case (r_state)
        S_IDLE: begin
          if (bus.i_start && (w_in_mul || w_in_div)) begin
            r_op <= bus.i_op[2:0];
            r_a  <= bus.i_a;
            r_b  <= bus.i_b;
          end
          if (bus.i_start) begin
            case (bus.i_op)
              4'd8:    r_hi     <= bus.i_a;
              4'd9:    r_lo     <= bus.i_a;
              4'd10:   r_result <= r_hi;
              4'd11:   r_result <= r_lo;
              default: r_result <= r_result;
            endcase
          end
        end
        S_ACC: {r_hi, r_lo} <= w_acc;
        S_DIV: begin
          if (r_cnt == {CW{1'b0}}) begin
            r_rem <= {WIDTH{1'b0}};
            r_quo <= w_a_mag;
            r_dvs <= w_b_mag;
          end else if (!w_diff[WIDTH]) begin
            r_rem <= w_diff[WIDTH-1:0];
            r_quo <= {r_quo[WIDTH-2:0], 1'b1};
          end else begin
            r_rem <= w_shift[WIDTH-1:0];
            r_quo <= {r_quo[WIDTH-2:0], 1'b0};
          end
        end
        S_FIX: begin
          r_hi <= w_r_fix;
          r_lo <= w_q_fix;
        end
        default: r_result <= r_result;
      endcase
    end
  end

  assign bus.o_busy        = r_busy;
  assign bus.o_done        = r_done;
  assign bus.o_div_by_zero = r_dbz;
  assign bus.o_result      = r_result;
  assign bus.o_hi          = r_hi;
  assign bus.o_lo          = r_lo;
endmodule
